// File: rtl/rf_seq.sv
// rf_seq: micro-sequencer driving the control lines of the A/B/C/D/F register
// file. It takes one register-transfer command at a time over valid/ready,
// then sequences write enables, bus output enables and data-in.
//
// Build option: define RF_SEQ_SWAP_EN to build the SWAP sequence (SW_RD,
// SW_WS and SW_WD states plus the tmp holding register). Without it, op 10
// completes as an illegal command: one no-op EXEC cycle, then done with err.
//
// state | meaning
// IDLE  | waiting for a command; cmd_ready high
// EXEC  | single-cycle LDI/MOV/CLR, or an enable-free pass for an illegal cmd
// SW_RD | SWAP: src driven onto the bus and captured into tmp
// SW_WS | SWAP: dst driven onto the bus and written into src
// SW_WD | SWAP: tmp written into dst
// FIN   | done pulse, with err for an illegal command; cmd_ready low

module rf_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_dst,
  input  logic [2:0] cmd_src,
  input  logic [7:0] cmd_imm,
  input  logic [7:0] rf_p,
  output logic [7:0] rf_d,
  output logic [4:0] rf_wi,
  output logic [3:0] rf_oe,
  output logic       rf_fo,
  output logic       done,
  output logic       err
);

  localparam logic [1:0] OP_LDI  = 2'b00;
  localparam logic [1:0] OP_MOV  = 2'b01;
  localparam logic [1:0] OP_SWAP = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

`ifdef RF_SEQ_SWAP_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EXEC  = 3'd1,
    SW_RD = 3'd2,
    SW_WS = 3'd3,
    SW_WD = 3'd4,
    FIN   = 3'd5
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    FIN  = 2'd2
  } state_t;
`endif

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [2:0] dst_q, dst_d;
  logic [1:0] src_q, src_d;
  logic [7:0] imm_q, imm_d;
  logic       ill_q, ill_d;

  logic       accept;
  logic       cmd_illegal;
  logic [4:0] dst_onehot;
  logic [3:0] src_onehot;

`ifdef RF_SEQ_SWAP_EN
  logic [7:0] tmp_q, tmp_d;
  logic [3:0] dst_bus_onehot;
  logic [4:0] src_wr_onehot;
`endif

  assign cmd_ready = (state_q == IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // Select decodes only matter for legal commands, where dst <= 4 and the
  // bus-side index fits in two bits; illegal values shift out to zero.
  assign dst_onehot = 5'b00001 << dst_q;
  assign src_onehot = 4'b0001 << src_q;

`ifdef RF_SEQ_SWAP_EN
  assign dst_bus_onehot = 4'b0001 << dst_q[1:0];
  assign src_wr_onehot  = {1'b0, src_onehot};
`endif

  // F is never driven onto the bus by this sequencer
  assign rf_fo = 1'b0;

  // Completion flags come straight from the FIN state so they are glitch-free
  assign done = (state_q == FIN);
  assign err  = done && ill_q;

  // Legality of the command currently presented on the cmd_* inputs
  always_comb begin
    cmd_illegal = (cmd_dst > 3'd4);
    case (cmd_op)
      OP_MOV: begin
        if (cmd_src[2]) cmd_illegal = 1'b1;
      end
`ifdef RF_SEQ_SWAP_EN
      OP_SWAP: begin
        if (cmd_src[2] || cmd_dst[2]) cmd_illegal = 1'b1;
      end
`else
      OP_SWAP: begin
        cmd_illegal = 1'b1;
      end
`endif
      default: begin
      end
    endcase
  end

  // Capture the command fields at acceptance and hold them until IDLE again
  always_comb begin
    op_d  = op_q;
    dst_d = dst_q;
    src_d = src_q;
    imm_d = imm_q;
    ill_d = ill_q;
    if (accept) begin
      op_d  = cmd_op;
      dst_d = cmd_dst;
      src_d = cmd_src[1:0];
      imm_d = cmd_imm;
      ill_d = cmd_illegal;
    end
  end

`ifdef RF_SEQ_SWAP_EN
  // tmp holds the original src value across the two SWAP write cycles
  always_comb begin
    tmp_d = tmp_q;
    if (state_q == SW_RD) tmp_d = rf_p;
  end
`endif

  // Next-state and control-line decode from the state and latched fields
  always_comb begin
    state_d = state_q;
    rf_d    = 8'h00;
    rf_wi   = 5'b00000;
    rf_oe   = 4'b0000;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
`ifdef RF_SEQ_SWAP_EN
          if ((cmd_op == OP_SWAP) && !cmd_illegal) state_d = SW_RD;
`endif
        end
      end
      EXEC: begin
        state_d = FIN;
        if (!ill_q) begin
          case (op_q)
            OP_LDI: begin
              rf_d  = imm_q;
              rf_wi = dst_onehot;
            end
            OP_MOV: begin
              rf_oe = src_onehot;
              rf_d  = rf_p;
              rf_wi = dst_onehot;
            end
            OP_CLR: begin
              rf_d  = 8'h00;
              rf_wi = imm_q[4:0];
            end
            default: begin
            end
          endcase
        end
      end
`ifdef RF_SEQ_SWAP_EN
      SW_RD: begin
        state_d = SW_WS;
        rf_oe   = src_onehot;
      end
      SW_WS: begin
        state_d = SW_WD;
        rf_oe   = dst_bus_onehot;
        rf_d    = rf_p;
        rf_wi   = src_wr_onehot;
      end
      SW_WD: begin
        state_d = FIN;
        rf_d    = tmp_q;
        rf_wi   = dst_onehot;
      end
`endif
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched command fields; reset discards any command in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 2'b00;
      dst_q   <= 3'd0;
      src_q   <= 2'd0;
      imm_q   <= 8'h00;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      imm_q   <= imm_d;
      ill_q   <= ill_d;
    end
  end

`ifdef RF_SEQ_SWAP_EN
  // SWAP holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmp_q <= 8'h00;
    end else begin
      tmp_q <= tmp_d;
    end
  end
`endif

endmodule

// File: tb/tb_rf_seq.sv
// Testbench for rf_seq. Models the five-register file around the DUT and
// checks directed scenarios plus a randomized command stream against a
// behavioural model of register-transfer results. Honours RF_SEQ_SWAP_EN.

module tb_rf_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [2:0] cmd_dst = 3'd0;
  logic [2:0] cmd_src = 3'd0;
  logic [7:0] cmd_imm = 8'h00;
  logic [7:0] rf_p;
  logic [7:0] rf_d;
  logic [4:0] rf_wi;
  logic [3:0] rf_oe;
  logic       rf_fo;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  rf_seq dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_dst   (cmd_dst),
    .cmd_src   (cmd_src),
    .cmd_imm   (cmd_imm),
    .rf_p      (rf_p),
    .rf_d      (rf_d),
    .rf_wi     (rf_wi),
    .rf_oe     (rf_oe),
    .rf_fo     (rf_fo),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file environment: A..D readable on the bus, F write-only here
  logic [7:0] rf [5] = '{default: 8'h00};
  logic [7:0] exp_rf [5] = '{default: 8'h00};

  always @(posedge clk) begin
    for (int i = 0; i < 5; i++) if (rf_wi[i]) rf[i] <= rf_d;
  end

  always_comb begin
    rf_p = 8'h00;
    case (rf_oe)
      4'b0001: rf_p = rf[0];
      4'b0010: rf_p = rf[1];
      4'b0100: rf_p = rf[2];
      4'b1000: rf_p = rf[3];
      default: rf_p = 8'h00;
    endcase
  end

  // Per-command trace, index 0 = sample just after the accepting edge
  logic [4:0] tr_wi [12];
  logic [3:0] tr_oe [12];
  logic [7:0] tr_d [12];
  logic       tr_done [12];
  logic       tr_err [12];
  logic       tr_ready [12];
  logic       tr_fo [12];
  int         tr_n;
  int         acc_cycle;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: applies a command to exp_rf, returns its legality
  function automatic bit model_cmd(input logic [1:0] op, input logic [2:0] dst,
                                   input logic [2:0] src, input logic [7:0] imm);
    bit legal;
    logic [7:0] t;
    legal = (dst <= 3'd4);
    if (op == 2'b01 && src > 3'd3) legal = 1'b0;
    if (op == 2'b10) begin
`ifdef RF_SEQ_SWAP_EN
      if (src > 3'd3 || dst > 3'd3) legal = 1'b0;
`else
      legal = 1'b0;
`endif
    end
    if (legal) begin
      case (op)
        2'b00: exp_rf[dst] = imm;
        2'b01: exp_rf[dst] = exp_rf[src];
        2'b10: begin
          t = exp_rf[src];
          exp_rf[src] = exp_rf[dst];
          exp_rf[dst] = t;
        end
        default: begin
          for (int i = 0; i < 5; i++) if (imm[i]) exp_rf[i] = 8'h00;
        end
      endcase
    end
    return legal;
  endfunction

  // Issue one command, then record outputs each cycle until cmd_ready returns.
  // While busy the command inputs are scrambled to prove they are ignored.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] dst,
                         input logic [2:0] src, input logic [7:0] imm);
    int guard;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (!cmd_ready) begin
      n_fail++;
      $display("FAIL ready_wait: cmd_ready=%b required 1 within 20 cycles", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_dst   = dst;
    cmd_src   = src;
    cmd_imm   = imm;
    tick();
    acc_cycle = cyc;
    tr_n = 0;
    for (int k = 0; k < 12; k++) begin
      tr_wi[k]    = rf_wi;
      tr_oe[k]    = rf_oe;
      tr_d[k]     = rf_d;
      tr_done[k]  = done;
      tr_err[k]   = err;
      tr_ready[k] = cmd_ready;
      tr_fo[k]    = rf_fo;
      tr_n = k + 1;
      if (cmd_ready || done) begin
        cmd_valid = 1'b0;
      end else begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_op    = 2'($urandom);
        cmd_dst   = 3'($urandom);
        cmd_src   = 3'($urandom);
        cmd_imm   = 8'($urandom);
      end
      if (cmd_ready) break;
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  function automatic int first_done();
    for (int k = 0; k < tr_n; k++) if (tr_done[k]) return k;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b required 1", cmd_ready); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b required 0", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b required 0", err); end
    n_checks++; if (rf_wi !== 5'b00000) begin n_fail++; $display("FAIL rst_wi: got %b required 00000", rf_wi); end
    n_checks++; if (rf_oe !== 4'b0000) begin n_fail++; $display("FAIL rst_oe: got %b required 0000", rf_oe); end
    n_checks++; if (rf_fo !== 1'b0) begin n_fail++; $display("FAIL rst_fo: got %b required 0", rf_fo); end
    n_checks++; if (rf_d !== 8'h00) begin n_fail++; $display("FAIL rst_d: got %h required 00", rf_d); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b required 1", cmd_ready); end
  endtask

  task automatic test_ldi();
    bit legal;
    run_cmd(2'b00, 3'd2, 3'd0, 8'h5A);
    legal = model_cmd(2'b00, 3'd2, 3'd0, 8'h5A);
    n_checks++; if (tr_wi[0] !== 5'b00100) begin n_fail++; $display("FAIL ldi_wi: got %b required 00100", tr_wi[0]); end
    n_checks++; if (tr_d[0] !== 8'h5A) begin n_fail++; $display("FAIL ldi_d: got %h required 5a", tr_d[0]); end
    n_checks++; if (tr_done[0] !== 1'b0 || tr_done[1] !== 1'b1) begin n_fail++; $display("FAIL ldi_done_timing: got %b%b required 01", tr_done[0], tr_done[1]); end
    n_checks++; if (tr_err[1] !== 1'b0) begin n_fail++; $display("FAIL ldi_err: got %b required 0", tr_err[1]); end
    n_checks++; if (tr_wi[1] !== 5'b00000) begin n_fail++; $display("FAIL ldi_wi_fin: got %b required 00000", tr_wi[1]); end
    n_checks++; if (tr_n !== 3 || tr_ready[2] !== 1'b1) begin n_fail++; $display("FAIL ldi_ready_return: got %0d samples required 3", tr_n); end
    n_checks++; if (rf[2] !== 8'h5A || !legal) begin n_fail++; $display("FAIL ldi_reg_c: got %h required 5a", rf[2]); end
  endtask

  task automatic test_mov();
    bit legal;
    run_cmd(2'b00, 3'd0, 3'd0, 8'h11);
    legal = model_cmd(2'b00, 3'd0, 3'd0, 8'h11);
    run_cmd(2'b01, 3'd4, 3'd0, 8'h00);
    legal = model_cmd(2'b01, 3'd4, 3'd0, 8'h00);
    n_checks++; if (tr_oe[0] !== 4'b0001) begin n_fail++; $display("FAIL mov_oe: got %b required 0001", tr_oe[0]); end
    n_checks++; if (tr_d[0] !== 8'h11) begin n_fail++; $display("FAIL mov_d: got %h required 11", tr_d[0]); end
    n_checks++; if (tr_wi[0] !== 5'b10000) begin n_fail++; $display("FAIL mov_wi: got %b required 10000", tr_wi[0]); end
    n_checks++; if (tr_done[1] !== 1'b1 || tr_err[1] !== 1'b0) begin n_fail++; $display("FAIL mov_done: got done=%b err=%b required 1 0", tr_done[1], tr_err[1]); end
    n_checks++; if (rf[4] !== 8'h11 || !legal) begin n_fail++; $display("FAIL mov_reg_f: got %h required 11", rf[4]); end
  endtask

  task automatic test_swap();
    bit legal;
    run_cmd(2'b00, 3'd1, 3'd0, 8'h22);
    legal = model_cmd(2'b00, 3'd1, 3'd0, 8'h22);
    run_cmd(2'b00, 3'd3, 3'd0, 8'h44);
    legal = model_cmd(2'b00, 3'd3, 3'd0, 8'h44);
    run_cmd(2'b10, 3'd3, 3'd1, 8'h00);
    legal = model_cmd(2'b10, 3'd3, 3'd1, 8'h00);
`ifdef RF_SEQ_SWAP_EN
    n_checks++; if (tr_oe[0] !== 4'b0010 || tr_wi[0] !== 5'b00000) begin n_fail++; $display("FAIL swap_rd: got oe=%b wi=%b required 0010 00000", tr_oe[0], tr_wi[0]); end
    n_checks++; if (tr_oe[1] !== 4'b1000 || tr_wi[1] !== 5'b00010 || tr_d[1] !== 8'h44) begin n_fail++; $display("FAIL swap_ws: got oe=%b wi=%b d=%h required 1000 00010 44", tr_oe[1], tr_wi[1], tr_d[1]); end
    n_checks++; if (tr_wi[2] !== 5'b01000 || tr_d[2] !== 8'h22) begin n_fail++; $display("FAIL swap_wd: got wi=%b d=%h required 01000 22", tr_wi[2], tr_d[2]); end
    n_checks++; if (first_done() !== 3 || tr_err[3] !== 1'b0) begin n_fail++; $display("FAIL swap_done: got idx %0d required 3", first_done()); end
    n_checks++; if (rf[1] !== 8'h44 || rf[3] !== 8'h22 || !legal) begin n_fail++; $display("FAIL swap_regs: got B=%h D=%h required 44 22", rf[1], rf[3]); end
`else
    n_checks++; if (tr_wi[0] !== 5'b00000 || tr_oe[0] !== 4'b0000) begin n_fail++; $display("FAIL swap_off_enables: got wi=%b oe=%b required 0", tr_wi[0], tr_oe[0]); end
    n_checks++; if (first_done() !== 1 || tr_err[1] !== 1'b1) begin n_fail++; $display("FAIL swap_off_err: got idx %0d err=%b required 1 1", first_done(), tr_err[1]); end
    n_checks++; if (rf[1] !== 8'h22 || rf[3] !== 8'h44 || legal) begin n_fail++; $display("FAIL swap_off_regs: got B=%h D=%h required 22 44", rf[1], rf[3]); end
`endif
  endtask

  task automatic test_clr();
    bit legal;
    bit bad;
    run_cmd(2'b11, 3'd0, 3'd0, 8'h1F);
    legal = model_cmd(2'b11, 3'd0, 3'd0, 8'h1F);
    n_checks++; if (tr_wi[0] !== 5'b11111 || tr_d[0] !== 8'h00) begin n_fail++; $display("FAIL clr_wi: got wi=%b d=%h required 11111 00", tr_wi[0], tr_d[0]); end
    n_checks++; if (tr_wi[1] !== 5'b00000 || tr_done[1] !== 1'b1) begin n_fail++; $display("FAIL clr_single_cycle: got wi=%b done=%b required 00000 1", tr_wi[1], tr_done[1]); end
    bad = !legal;
    for (int i = 0; i < 5; i++) if (rf[i] !== 8'h00) bad = 1'b1;
    n_checks++; if (bad) begin n_fail++; $display("FAIL clr_regs: got A=%h B=%h C=%h D=%h F=%h required all 00", rf[0], rf[1], rf[2], rf[3], rf[4]); end
  endtask

  task automatic test_illegal();
    bit legal;
    run_cmd(2'b01, 3'd0, 3'd4, 8'h00);
    legal = model_cmd(2'b01, 3'd0, 3'd4, 8'h00);
    n_checks++; if (tr_wi[0] !== 5'b0 || tr_oe[0] !== 4'b0 || tr_d[0] !== 8'h00) begin n_fail++; $display("FAIL ill_mov_enables: got wi=%b oe=%b d=%h required 0", tr_wi[0], tr_oe[0], tr_d[0]); end
    n_checks++; if (tr_done[1] !== 1'b1 || tr_err[1] !== 1'b1 || legal) begin n_fail++; $display("FAIL ill_mov_err: got done=%b err=%b required 1 1", tr_done[1], tr_err[1]); end
    run_cmd(2'b00, 3'd6, 3'd0, 8'hEE);
    legal = model_cmd(2'b00, 3'd6, 3'd0, 8'hEE);
    n_checks++; if (tr_wi[0] !== 5'b0 || tr_oe[0] !== 4'b0 || tr_d[0] !== 8'h00) begin n_fail++; $display("FAIL ill_ldi_enables: got wi=%b oe=%b d=%h required 0", tr_wi[0], tr_oe[0], tr_d[0]); end
    n_checks++; if (tr_done[1] !== 1'b1 || tr_err[1] !== 1'b1 || legal) begin n_fail++; $display("FAIL ill_ldi_err: got done=%b err=%b required 1 1", tr_done[1], tr_err[1]); end
    run_cmd(2'b00, 3'd1, 3'd0, 8'h3C);
    legal = model_cmd(2'b00, 3'd1, 3'd0, 8'h3C);
    n_checks++; if (tr_err[1] !== 1'b0 || rf[1] !== 8'h3C || !legal) begin n_fail++; $display("FAIL ill_recover: got err=%b B=%h required 0 3c", tr_err[1], rf[1]); end
  endtask

  task automatic test_back_to_back();
    bit legal;
    int a0, a1, a2;
    run_cmd(2'b00, 3'd0, 3'd0, 8'hA1);
    legal = model_cmd(2'b00, 3'd0, 3'd0, 8'hA1);
    a0 = acc_cycle;
    run_cmd(2'b00, 3'd2, 3'd0, 8'hC3);
    legal = model_cmd(2'b00, 3'd2, 3'd0, 8'hC3);
    a1 = acc_cycle;
    run_cmd(2'b01, 3'd3, 3'd2, 8'h00);
    legal = model_cmd(2'b01, 3'd3, 3'd2, 8'h00);
    a2 = acc_cycle;
    n_checks++; if ((a1 - a0) !== 3 || (a2 - a1) !== 3) begin n_fail++; $display("FAIL b2b_throughput: got spacing %0d %0d required 3 3", a1 - a0, a2 - a1); end
    n_checks++; if (rf[0] !== 8'hA1 || rf[2] !== 8'hC3 || rf[3] !== 8'hC3 || !legal) begin n_fail++; $display("FAIL b2b_regs: got A=%h C=%h D=%h required a1 c3 c3", rf[0], rf[2], rf[3]); end
  endtask

  task automatic test_reset_mid();
    bit legal;
    bit saw_done;
`ifdef RF_SEQ_SWAP_EN
    run_cmd(2'b00, 3'd1, 3'd0, 8'h5B);
    legal = model_cmd(2'b00, 3'd1, 3'd0, 8'h5B);
    run_cmd(2'b00, 3'd3, 3'd0, 8'hD0);
    legal = model_cmd(2'b00, 3'd3, 3'd0, 8'hD0);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_dst = 3'd3; cmd_src = 3'd1;
    tick();
    cmd_valid = 1'b0;
    tick();
    // the edge leaving SW_WS has written D's value into B; reset lands before D is written
    tick();
    n_checks++; if (rf_wi !== 5'b01000) begin n_fail++; $display("FAIL rmid_pre_wi: got %b required 01000", rf_wi); end
    exp_rf[1] = exp_rf[3];
`else
    run_cmd(2'b00, 3'd0, 3'd0, 8'h77);
    legal = model_cmd(2'b00, 3'd0, 3'd0, 8'h77);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_dst = 3'd0; cmd_imm = 8'hA5;
    tick();
    cmd_valid = 1'b0;
    n_checks++; if (rf_wi !== 5'b00001) begin n_fail++; $display("FAIL rmid_pre_wi: got %b required 00001", rf_wi); end
`endif
    rst = 1'b1;
    #1;
    n_checks++; if (rf_wi !== 5'b0 || rf_oe !== 4'b0 || rf_d !== 8'h00) begin n_fail++; $display("FAIL rmid_async_drop: got wi=%b oe=%b d=%h required 0", rf_wi, rf_oe, rf_d); end
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b required 1", cmd_ready); end
    saw_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    n_checks++; if (saw_done) begin n_fail++; $display("FAIL rmid_no_done: got done pulse required none"); end
    n_checks++; if (rf[0] !== exp_rf[0] || rf[1] !== exp_rf[1] || rf[3] !== exp_rf[3] || !legal) begin n_fail++; $display("FAIL rmid_regs: got A=%h B=%h D=%h required %h %h %h", rf[0], rf[1], rf[3], exp_rf[0], exp_rf[1], exp_rf[3]); end
  endtask

  task automatic test_random();
    bit         legal;
    bit         bad;
    int         exp_idx;
    int         didx;
    logic [1:0] op;
    logic [2:0] dst, src;
    logic [7:0] imm;
    for (int n = 0; n < 60; n++) begin
      op  = 2'($urandom_range(0, 3));
      dst = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      src = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      imm = 8'($urandom);
      run_cmd(op, dst, src, imm);
      legal   = model_cmd(op, dst, src, imm);
      exp_idx = (legal && op == 2'b10) ? 3 : 1;
      didx    = first_done();
      n_checks++; if (didx !== exp_idx) begin n_fail++; $display("FAIL rnd_done_idx[%0d]: op=%b got %0d required %0d", n, op, didx, exp_idx); end
      n_checks++; if (didx >= 0 && tr_err[didx] !== !legal) begin n_fail++; $display("FAIL rnd_err[%0d]: op=%b dst=%0d src=%0d got %b required %b", n, op, dst, src, tr_err[didx], !legal); end
      n_checks++; if (tr_n !== exp_idx + 2 || tr_ready[tr_n-1] !== 1'b1) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %0d samples required %0d", n, tr_n, exp_idx + 2); end
      bad = 1'b0;
      for (int k = 0; k < tr_n; k++) begin
        if ($countones(tr_oe[k]) > 1) bad = 1'b1;
        if (tr_fo[k] !== 1'b0) bad = 1'b1;
        if (tr_err[k] && !tr_done[k]) bad = 1'b1;
        if (!legal && (tr_wi[k] !== 5'b0 || tr_oe[k] !== 4'b0 || tr_d[k] !== 8'h00)) bad = 1'b1;
      end
      n_checks++; if (bad) begin n_fail++; $display("FAIL rnd_controls[%0d]: op=%b dst=%0d src=%0d illegal enable pattern", n, op, dst, src); end
      bad = 1'b0;
      for (int i = 0; i < 5; i++) if (rf[i] !== exp_rf[i]) bad = 1'b1;
      n_checks++; if (bad) begin n_fail++; $display("FAIL rnd_regs[%0d]: op=%b got %h %h %h %h %h required %h %h %h %h %h", n, op, rf[0], rf[1], rf[2], rf[3], rf[4], exp_rf[0], exp_rf[1], exp_rf[2], exp_rf[3], exp_rf[4]); end
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_mov();
    test_swap();
    test_clr();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
